// File: rtl/data_route_pkg.sv
// Shared definitions for the data_route phase scheduler: default widths,
// command field layout, monitored-port indices and FSM state encoding.
package data_route_pkg;

  localparam int SW_W_DEFAULT  = 36;
  localparam int CNT_W_DEFAULT = 16;

  localparam int SW0_LSB  = 0;
  localparam int SW1_LSB  = SW_W_DEFAULT;
  localparam int MSEL_LSB = 2 * SW_W_DEFAULT;
  localparam int CNT_LSB  = 2 * SW_W_DEFAULT + 3;

  localparam logic [2:0] PORT_A = 3'd0;
  localparam logic [2:0] PORT_B = 3'd1;
  localparam logic [2:0] PORT_C = 3'd2;
  localparam logic [2:0] PORT_D = 3'd3;
  localparam logic [2:0] PORT_E = 3'd4;
  localparam logic [2:0] PORT_F = 3'd5;
  localparam logic [2:0] PORT_G = 3'd6;
  localparam logic [2:0] PORT_H = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Field offsets for a non-default switch width.
  function automatic int sw1_lsb(input int sw_w);
    return sw_w;
  endfunction

  function automatic int msel_lsb(input int sw_w);
    return 2 * sw_w;
  endfunction

  function automatic int cnt_lsb(input int sw_w);
    return 2 * sw_w + 3;
  endfunction

endpackage

// File: rtl/data_route_ctrl_fifo.sv
// Synchronous command FIFO with a registered ready (not-full) flag that is low
// during reset and allows a simultaneous push and pop.
module droute_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_push,
  output logic             o_ready,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_nxt;

  assign w_push  = i_push & r_ready;
  assign w_pop   = i_pop & (r_count != '0);
  assign o_ready = r_ready;
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CNT_ONE;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= i_wdata;
  end

  // Ready follows the next occupancy, so a pop re-opens the queue one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)
        r_rptr <= r_rptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != FULL_CNT);
    end
  end

endmodule

// File: rtl/data_route_ctrl.sv
// Phase scheduler for data_route: pops queued route commands, holds the switch
// words for one phase and gates traffic until the selected port has moved beat_cnt beats.
module data_route_ctrl
  import data_route_pkg::*;
#(
  parameter int SW_W       = SW_W_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*SW_W+CNT_W+2:0]   s_cmd_tdata,
  input  logic                      s_cmd_tvalid,
  output logic                      s_cmd_tready,
  output logic [SW_W-1:0]           droute_switch_0,
  output logic [SW_W-1:0]           droute_switch_1,
  output logic                      route_en,
  input  logic [7:0]                mon_tvalid,
  input  logic [7:0]                mon_tready,
  output logic                      phase_done,
  output logic [7:0]                phase_id,
  output logic                      busy
);

  localparam int CMD_W  = 2*SW_W + CNT_W + 3;
  localparam int L_SW1  = sw1_lsb(SW_W);
  localparam int L_MSEL = msel_lsb(SW_W);
  localparam int L_CNT  = cnt_lsb(SW_W);
  localparam int SCW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] BEAT_ONE    = CNT_W'(1);

  state_t           r_state;
  logic [SW_W-1:0]  r_sw0;
  logic [SW_W-1:0]  r_sw1;
  logic [2:0]       r_msel;
  logic [CNT_W-1:0] r_beat;
  logic [CNT_W-1:0] r_cnt;
  logic [SCW-1:0]   r_settle;
  logic             r_route_en;
  logic             r_done;
  logic [7:0]       r_phase_id;

  logic [CMD_W-1:0] w_head;
  logic             w_empty;
  logic             w_pop;
  logic             w_hs;
  logic [CNT_W-1:0] w_h_cnt;

  assign w_pop   = (r_state == ST_LOAD);
  assign w_h_cnt = w_head[L_CNT +: CNT_W];
  assign w_hs    = mon_tvalid[r_msel] & mon_tready[r_msel];

  droute_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wdata (s_cmd_tdata),
    .i_push  (s_cmd_tvalid),
    .o_ready (s_cmd_tready),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sw0      <= '0;
      r_sw1      <= '0;
      r_msel     <= '0;
      r_beat     <= '0;
      r_cnt      <= '0;
      r_settle   <= '0;
      r_route_en <= 1'b0;
      r_done     <= 1'b0;
      r_phase_id <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty)
            r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_sw0    <= w_head[0 +: SW_W];
          r_sw1    <= w_head[L_SW1 +: SW_W];
          r_msel   <= w_head[L_MSEL +: 3];
          r_beat   <= w_h_cnt;
          r_cnt    <= '0;
          r_settle <= '0;
          if (SETTLE_CYC > 0) begin
            r_state <= ST_SETTLE;
          end else if (w_h_cnt == '0) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_phase_id <= r_phase_id + 8'd1;
          end else begin
            r_state    <= ST_RUN;
            r_route_en <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            if (r_beat == '0) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_phase_id <= r_phase_id + 8'd1;
            end else begin
              r_state    <= ST_RUN;
              r_route_en <= 1'b1;
            end
          end else begin
            r_settle <= r_settle + SCW'(1);
          end
        end
        ST_RUN: begin
          // The closing handshake is counted; enable drops on the same edge.
          if (w_hs) begin
            if (r_cnt == r_beat - BEAT_ONE) begin
              r_state    <= ST_DONE;
              r_route_en <= 1'b0;
              r_done     <= 1'b1;
              r_phase_id <= r_phase_id + 8'd1;
            end else begin
              r_cnt <= r_cnt + BEAT_ONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= w_empty ? ST_IDLE : ST_LOAD;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_route_en <= 1'b0;
        end
      endcase
    end
  end

  assign droute_switch_0 = r_sw0;
  assign droute_switch_1 = r_sw1;
  assign route_en        = r_route_en;
  assign phase_done      = r_done;
  assign phase_id        = r_phase_id;
  assign busy            = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_data_route_ctrl.sv
// Directed bench for data_route_ctrl: reset, single phase timing, port select
// under backpressure, queue full, zero-beat phase and reset mid-phase.
module tb_data_route_ctrl;
  import data_route_pkg::*;

  localparam int SW_W  = 36;
  localparam int CNT_W = 16;
  localparam int CMD_W = 2*SW_W + CNT_W + 3;

  logic             clk;
  logic             rst;
  logic [CMD_W-1:0] s_cmd_tdata;
  logic             s_cmd_tvalid;
  logic             s_cmd_tready;
  logic [SW_W-1:0]  droute_switch_0;
  logic [SW_W-1:0]  droute_switch_1;
  logic             route_en;
  logic [7:0]       mon_tvalid;
  logic [7:0]       mon_tready;
  logic             phase_done;
  logic [7:0]       phase_id;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]      id;
    logic [SW_W-1:0] s0;
    logic [SW_W-1:0] s1;
  } ev_t;
  ev_t evq[$];

  data_route_ctrl #(
    .SW_W       (SW_W),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (4),
    .SETTLE_CYC (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_cmd_tdata     (s_cmd_tdata),
    .s_cmd_tvalid    (s_cmd_tvalid),
    .s_cmd_tready    (s_cmd_tready),
    .droute_switch_0 (droute_switch_0),
    .droute_switch_1 (droute_switch_1),
    .route_en        (route_en),
    .mon_tvalid      (mon_tvalid),
    .mon_tready      (mon_tready),
    .phase_done      (phase_done),
    .phase_id        (phase_id),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed phase with the switch words it ran under.
  always @(negedge clk) begin
    if (phase_done)
      evq.push_back('{phase_id, droute_switch_0, droute_switch_1});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [CNT_W-1:0] b, input logic [2:0] m,
                                               input logic [SW_W-1:0] s1, input logic [SW_W-1:0] s0);
    return {b, m, s1, s0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_cmd_tvalid = 1'b1;
    s_cmd_tdata = mk_cmd(16'd5, PORT_A, 36'h1, 36'h2);
    mon_tvalid = 8'h00;
    mon_tready = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (s_cmd_tready !== 1'b0) begin
        n_err++;
        $display("FAIL rst_tready_low: got %b want 0", s_cmd_tready);
      end
    end
    rst = 1'b0;
    s_cmd_tvalid = 1'b0;
    tick();
    n_vec++;
    if (s_cmd_tready !== 1'b1) begin n_err++; $display("FAIL rst_tready_high: got %b want 1", s_cmd_tready); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++;
    if ({route_en, phase_done} !== 2'b00) begin n_err++; $display("FAIL rst_en_done: got %b want 00", {route_en, phase_done}); end
    n_vec++;
    if (phase_id !== 8'd0) begin n_err++; $display("FAIL rst_phase_id: got %0d want 0", phase_id); end
    n_vec++;
    if ({droute_switch_1, droute_switch_0} !== '0) begin
      n_err++; $display("FAIL rst_switches: got %h/%h want 0/0", droute_switch_1, droute_switch_0);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_no_push: busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic exp_en, exp_done;
    mon_tvalid = 8'h01;
    mon_tready = 8'h01;
    s_cmd_tdata = mk_cmd(16'd10, PORT_A, 36'h8048, 36'h10099);
    s_cmd_tvalid = 1'b1;
    tick();
    s_cmd_tvalid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_en = (k >= 4 && k <= 13);
      exp_done = (k == 14);
      n_vec++;
      if (route_en !== exp_en) begin n_err++; $display("FAIL single_route_en t+%0d: got %b want %b", k, route_en, exp_en); end
      n_vec++;
      if (phase_done !== exp_done) begin n_err++; $display("FAIL single_phase_done t+%0d: got %b want %b", k, phase_done, exp_done); end
      if (k == 1) begin
        n_vec++;
        if ({droute_switch_1, droute_switch_0} !== '0) begin
          n_err++; $display("FAIL single_sw_early: got %h/%h want 0/0", droute_switch_1, droute_switch_0);
        end
      end else begin
        n_vec++;
        if (droute_switch_0 !== 36'h10099 || droute_switch_1 !== 36'h8048) begin
          n_err++; $display("FAIL single_sw t+%0d: got %h/%h want 8048/10099", k, droute_switch_1, droute_switch_0);
        end
      end
    end
    n_vec++;
    if (phase_id !== 8'd1) begin n_err++; $display("FAIL single_phase_id: got %0d want 1", phase_id); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    logic seen = 1'b0;
    logic r, hs;
    mon_tvalid = 8'hFF;
    mon_tready = 8'h0F;
    s_cmd_tdata = mk_cmd(16'd120, PORT_E, 36'hA5, 36'h5A);
    s_cmd_tvalid = 1'b1;
    tick();
    s_cmd_tvalid = 1'b0;
    for (int c = 0; c < 2000 && !seen && cnt <= 120; c++) begin
      r = 1'($urandom_range(0, 1));
      mon_tready = {3'b111, r, 4'b1111};
      hs = route_en & r;
      tick();
      if (hs) cnt++;
      n_vec++;
      if (phase_done !== (hs && cnt == 120)) begin
        n_err++; $display("FAIL bp_phase_done beat %0d: got %b want %b", cnt, phase_done, (hs && cnt == 120));
      end
      if (phase_done) seen = 1'b1;
    end
    n_vec++;
    if (!seen || cnt != 120) begin n_err++; $display("FAIL bp_done_count: done %b after %0d beats want 1 after 120", seen, cnt); end
    n_vec++;
    if (route_en !== 1'b0) begin n_err++; $display("FAIL bp_route_en_drop: got %b want 0", route_en); end
    n_vec++;
    if (phase_id !== 8'd2) begin n_err++; $display("FAIL bp_phase_id: got %0d want 2", phase_id); end
    mon_tready = 8'h00;
    tick();
  endtask

  task automatic test_queue_full();
    logic [CMD_W-1:0] cmds [5];
    logic [SW_W-1:0]  e0 [6];
    logic [SW_W-1:0]  e1 [6];
    int waits [5];
    int g;
    logic [7:0] base;
    evq.delete();
    base = phase_id;
    mon_tvalid = 8'hFF;
    mon_tready = 8'hFF;
    e0[0] = 36'h200;
    e1[0] = 36'h100;
    s_cmd_tdata = mk_cmd(16'd6, PORT_B, 36'h100, 36'h200);
    s_cmd_tvalid = 1'b1;
    tick();
    s_cmd_tvalid = 1'b0;
    g = 0;
    while (route_en !== 1'b1 && g < 20) begin tick(); g++; end
    n_vec++;
    if (route_en !== 1'b1) begin n_err++; $display("FAIL qf_first_run: route_en got %b want 1", route_en); end
    for (int i = 0; i < 5; i++) begin
      e1[i+1] = 36'h1000 + SW_W'(i);
      e0[i+1] = 36'h2000 + SW_W'(i);
      cmds[i] = mk_cmd(16'd3, 3'(i), e1[i+1], e0[i+1]);
      s_cmd_tdata = cmds[i];
      s_cmd_tvalid = 1'b1;
      waits[i] = 0;
      while (s_cmd_tready !== 1'b1 && waits[i] < 50) begin tick(); waits[i]++; end
      tick();
      if (i == 3) begin
        n_vec++;
        if (s_cmd_tready !== 1'b0) begin n_err++; $display("FAIL qf_full_tready: got %b want 0", s_cmd_tready); end
      end
    end
    s_cmd_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (waits[i] != 0) begin n_err++; $display("FAIL qf_accept_%0d: waited %0d want 0", i, waits[i]); end
    end
    n_vec++;
    if (waits[4] == 0 || waits[4] >= 50) begin n_err++; $display("FAIL qf_fifth_blocked: waited %0d want 1..49", waits[4]); end
    g = 0;
    while (busy !== 1'b0 && g < 200) begin tick(); g++; end
    tick();
    n_vec++;
    if (evq.size() != 6) begin n_err++; $display("FAIL qf_phase_count: got %0d want 6", evq.size()); end
    for (int j = 0; j < 6 && j < evq.size(); j++) begin
      n_vec++;
      if (evq[j].id !== 8'(base + 8'(j + 1)) || evq[j].s0 !== e0[j] || evq[j].s1 !== e1[j]) begin
        n_err++;
        $display("FAIL qf_phase_%0d: got id %0d sw %h/%h want id %0d sw %h/%h",
                 j, evq[j].id, evq[j].s1, evq[j].s0, 8'(base + 8'(j + 1)), e1[j], e0[j]);
      end
    end
  endtask

  task automatic test_zero_beat();
    logic [7:0] base;
    base = phase_id;
    mon_tvalid = 8'hFF;
    mon_tready = 8'hFF;
    s_cmd_tdata = mk_cmd(16'd0, PORT_C, 36'hF00000001, 36'hE00000002);
    s_cmd_tvalid = 1'b1;
    tick();
    s_cmd_tvalid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_vec++;
      if (route_en !== 1'b0) begin n_err++; $display("FAIL zb_route_en t+%0d: got %b want 0", k, route_en); end
      n_vec++;
      if (phase_done !== (k == 4)) begin n_err++; $display("FAIL zb_phase_done t+%0d: got %b want %b", k, phase_done, (k == 4)); end
      if (k >= 2) begin
        n_vec++;
        if (droute_switch_0 !== 36'hE00000002 || droute_switch_1 !== 36'hF00000001) begin
          n_err++; $display("FAIL zb_sw t+%0d: got %h/%h want F00000001/E00000002", k, droute_switch_1, droute_switch_0);
        end
      end
    end
    n_vec++;
    if (phase_id !== 8'(base + 8'd1)) begin n_err++; $display("FAIL zb_phase_id: got %0d want %0d", phase_id, 8'(base + 8'd1)); end
  endtask

  task automatic test_reset_mid_run();
    int g;
    logic seen;
    mon_tvalid = 8'hFF;
    mon_tready = 8'h00;
    s_cmd_tvalid = 1'b1;
    s_cmd_tdata = mk_cmd(16'd10, PORT_A, 36'h111, 36'h222);
    tick();
    s_cmd_tdata = mk_cmd(16'd4, PORT_A, 36'h555, 36'h666);
    tick();
    s_cmd_tdata = mk_cmd(16'd4, PORT_A, 36'h777, 36'h888);
    tick();
    s_cmd_tvalid = 1'b0;
    g = 0;
    while (route_en !== 1'b1 && g < 20) begin tick(); g++; end
    evq.delete();
    mon_tready = 8'h01;
    repeat (5) tick();
    mon_tready = 8'h00;
    n_vec++;
    if (route_en !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL mr_mid_phase: en/busy got %b%b want 11", route_en, busy); end
    rst = 1'b1;
    tick();
    n_vec++;
    if (route_en !== 1'b0 || busy !== 1'b0 || phase_done !== 1'b0) begin
      n_err++; $display("FAIL mr_outputs: en/busy/done got %b%b%b want 000", route_en, busy, phase_done);
    end
    n_vec++;
    if (phase_id !== 8'd0) begin n_err++; $display("FAIL mr_phase_id: got %0d want 0", phase_id); end
    n_vec++;
    if ({droute_switch_1, droute_switch_0} !== '0 || s_cmd_tready !== 1'b0) begin
      n_err++; $display("FAIL mr_sw_tready: got %h/%h rdy %b want 0/0 rdy 0", droute_switch_1, droute_switch_0, s_cmd_tready);
    end
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (s_cmd_tready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL mr_release: rdy/busy got %b%b want 10", s_cmd_tready, busy);
    end
    repeat (3) tick();
    n_vec++;
    if (evq.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mr_abandoned: %0d phase_done busy %b want 0 and 0", evq.size(), busy);
    end
    mon_tready = 8'hFF;
    s_cmd_tdata = mk_cmd(16'd2, PORT_D, 36'h333, 36'h444);
    s_cmd_tvalid = 1'b1;
    tick();
    s_cmd_tvalid = 1'b0;
    seen = 1'b0;
    g = 0;
    while (!seen && g < 30) begin tick(); g++; if (phase_done === 1'b1) seen = 1'b1; end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL mr_post_done: got no phase_done want one within 30 cycles"); end
    n_vec++;
    if (phase_id !== 8'd1 || droute_switch_0 !== 36'h444 || droute_switch_1 !== 36'h333) begin
      n_err++; $display("FAIL mr_post_phase: got id %0d sw %h/%h want id 1 sw 333/444", phase_id, droute_switch_1, droute_switch_0);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_cmd_tvalid = 1'b0;
    s_cmd_tdata = '0;
    mon_tvalid = 8'h00;
    mon_tready = 8'h00;
    test_reset();
    test_single();
    test_backpressure();
    test_queue_full();
    test_zero_beat();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
